// File: rtl/normalizer_if.sv
// normalizer_if: handshake and data bundle for the normalizer.
//   i_valid / o_ready              : input word handshake
//   i_data, i_signed               : word to normalize and its mode (1 = two's complement)
//   o_valid / i_ready              : result handshake
//   o_result, o_shift, o_zero      : normalized word, left-shift applied, zero-input flag
// Modports: slave (the normalizer side), master (the producer/consumer side).
`timescale 1ns/1ps
interface normalizer_if #(
    parameter int WIDTH       = 32,
    parameter int SHIFT_WIDTH = 5
);
    logic                   i_valid;
    logic                   o_ready;
    logic [WIDTH-1:0]       i_data;
    logic                   i_signed;
    logic                   o_valid;
    logic                   i_ready;
    logic [WIDTH-1:0]       o_result;
    logic [SHIFT_WIDTH-1:0] o_shift;
    logic                   o_zero;

    modport slave (
        input  i_valid, i_data, i_signed, i_ready,
        output o_ready, o_valid, o_result, o_shift, o_zero
    );

    modport master (
        output i_valid, i_data, i_signed, i_ready,
        input  o_ready, o_valid, o_result, o_shift, o_zero
    );
endinterface

// File: rtl/normalizer.sv
// normalizer: finds the left shift that normalizes a word (the inverse of the
// barrel shifter) by stepping the word left one bit per cycle.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : normalizer_if.slave (i_valid/o_ready in, o_valid/i_ready out,
//             i_data, i_signed, o_result, o_shift, o_zero)
// Optional feature: define NORMALIZER_NIBBLE_SKIP_EN to let the SHIFT state
// jump 4 bits at once when the top nibble is pure fill; results are unchanged,
// only latency shortens.
`timescale 1ns/1ps
module normalizer #(
    parameter int WIDTH       = 32,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    normalizer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [SHIFT_WIDTH-1:0] LAST_COUNT = SHIFT_WIDTH'(WIDTH - 1);
`ifdef NORMALIZER_NIBBLE_SKIP_EN
    localparam logic [SHIFT_WIDTH-1:0] SKIP_LIMIT = SHIFT_WIDTH'(WIDTH - 5);
`endif

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       word_q, word_d;
    logic [SHIFT_WIDTH-1:0] count_q, count_d;
    logic                   sgn_q, sgn_d;
    logic                   zero_q, zero_d;

    // Unsigned: MSB set. Signed: the two top bits differ (sign bit is the
    // only copy of the sign).
    function automatic logic is_normalized(input logic [WIDTH-1:0] w, input logic sgn);
        if (sgn)
            return w[WIDTH-1] ^ w[WIDTH-2];
        else
            return w[WIDTH-1];
    endfunction

`ifdef NORMALIZER_NIBBLE_SKIP_EN
    // A 4-bit jump is safe only if the single-step path would take at least
    // four more steps: top 4 bits zero (unsigned) or top 5 bits all equal to
    // the sign (signed).
    function automatic logic nibble_skip_ok(input logic [WIDTH-1:0] w, input logic sgn);
        if (sgn)
            return w[WIDTH-1 -: 5] == {5{w[WIDTH-1]}};
        else
            return w[WIDTH-1 -: 4] == 4'b0000;
    endfunction
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            count_q <= '0;
            sgn_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            count_q <= count_d;
            sgn_q   <= sgn_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        count_d = count_q;
        sgn_d   = sgn_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                // o_ready is 1 throughout IDLE, so i_valid alone completes the handshake.
                if (bus.i_valid) begin
                    state_d = SHIFT;
                    word_d  = bus.i_data;
                    sgn_d   = bus.i_signed;
                    count_d = '0;
                    zero_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (word_q == '0) begin
                    state_d = DONE;
                    zero_d  = 1'b1;
                end else if (is_normalized(word_q, sgn_q) || (count_q == LAST_COUNT)) begin
                    state_d = DONE;
`ifdef NORMALIZER_NIBBLE_SKIP_EN
                end else if (nibble_skip_ok(word_q, sgn_q) && (count_q <= SKIP_LIMIT)) begin
                    word_d  = word_q << 4;
                    count_d = count_q + SHIFT_WIDTH'(4);
`endif
                end else begin
                    word_d  = word_q << 1;
                    count_d = count_q + SHIFT_WIDTH'(1);
                end
            end
            DONE: begin
                // Result registers are untouched here, so outputs hold until taken.
                if (bus.i_ready)
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.o_ready  = (state_q == IDLE);
    assign bus.o_valid  = (state_q == DONE);
    assign bus.o_result = word_q;
    assign bus.o_shift  = count_q;
    assign bus.o_zero   = zero_q;

endmodule

// File: doc/normalizer.md
NORMALIZER -- requirements
Module: normalizer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32 (`WIDTH), giving the data word width.
REQ-002 The block SHALL have parameter SHIFT_WIDTH, default 5 (`SHIFT_WIDTH), giving the shift-count width (log2 WIDTH).
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port i_valid, input, 1 bit: the input word is presented.
REQ-006 The block SHALL have port o_ready, output, 1 bit: the block can accept a word.
REQ-007 The block SHALL have port i_data, input, WIDTH bits: the word to normalize.
REQ-008 The block SHALL have port i_signed, input, 1 bit: 1 selects two's-complement normalization, 0 selects unsigned; sampled at acceptance.
REQ-009 The block SHALL have port o_valid, output, 1 bit: the result is available.
REQ-010 The block SHALL have port i_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port o_result, output, WIDTH bits: the normalized word.
REQ-012 The block SHALL have port o_shift, output, SHIFT_WIDTH bits: the left-shift amount applied.
REQ-013 The block SHALL have port o_zero, output, 1 bit: the input was zero.

Function
REQ-014 The block SHALL compute the left-shift amount that normalizes a word, the inverse of the team's barrel shifter, so that shifting i_data left by o_shift gives o_result.
REQ-015 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-016 o_ready SHALL be 1 only in IDLE, and o_valid SHALL be 1 only in DONE.
REQ-017 In IDLE, when i_valid and o_ready are both 1, the block SHALL load i_data and i_signed, clear the count to 0, and go to SHIFT.
REQ-018 An unsigned word SHALL count as normalized when bit WIDTH-1 is 1.
REQ-019 A signed word SHALL count as normalized when bit WIDTH-1 differs from bit WIDTH-2.
REQ-020 In SHIFT, each cycle, the block SHALL go to DONE if the word is normalized, zero, or the count equals WIDTH-1; otherwise it SHALL shift left by 1 with zero fill and increment the count.
REQ-021 The latency SHALL be n+1 cycles from the acceptance edge to o_valid, where n is the required shift.
REQ-022 A zero input SHALL give o_zero=1, o_result=0, o_shift=0 and latency 1.
REQ-023 In DONE, o_result, o_shift and o_zero SHALL be held stable until i_ready is 1; the block SHALL then return to IDLE on that edge.
REQ-024 A new word SHALL be accepted no earlier than the cycle after the DONE handshake, with no overlap.
REQ-025 i_data and i_signed SHALL be ignored outside IDLE.
REQ-026 Signed all-ones (-1) SHALL give o_shift=WIDTH-1 and o_result=0x80000000.

Reset
REQ-027 Assertion of i_rst_n low SHALL immediately force IDLE, o_valid=0, o_result=0, o_shift=0, o_zero=0 and o_ready=1, regardless of clock.
REQ-028 Reset asserted during SHIFT or DONE SHALL discard the word in flight, and no o_valid SHALL follow.
REQ-029 After deassertion, the first acceptance SHALL be possible on the first rising edge.

Configuration
REQ-030 When the macro NORMALIZER_NIBBLE_SKIP_EN is defined, in SHIFT the block SHALL shift by 4 and add 4 to the count in one cycle if the top 4 bits (unsigned) or the top 5 bits (signed) are all equal to the fill/sign condition and the count is at most WIDTH-5; otherwise it SHALL step by 1.
REQ-031 When NORMALIZER_NIBBLE_SKIP_EN is not defined, the block SHALL step by 1 only.
REQ-032 o_result, o_shift and o_zero SHALL be identical with and without NORMALIZER_NIBBLE_SKIP_EN; only latency SHALL differ.

Verification
REQ-033 The bench SHALL apply unsigned 0x00000001 and check o_result=0x80000000, o_shift=31 and o_valid 32 cycles after acceptance (macro off).
REQ-034 The bench SHALL apply unsigned 0x80000000 and check o_shift=0, same o_result, o_valid after 1 cycle, and o_ready=0 during SHIFT.
REQ-035 The bench SHALL apply signed 0xFFFF0000 and check o_result=0x80000000, o_shift=15; then signed 0xFFFFFFFF and check o_shift=31.
REQ-036 The bench SHALL apply 0x00000000 and check o_zero=1, o_result=0, o_shift=0 after 1 cycle.
REQ-037 The bench SHALL hold i_ready=0 for 5 cycles in DONE and check that outputs stay stable and i_valid is not accepted; it SHALL then pulse i_ready and check IDLE on the next cycle.
REQ-038 The bench SHALL assert i_rst_n low mid-SHIFT on input 0x00000100 and check o_valid=0 and o_ready=1 immediately, with no stale result after release.
